cfg_loader: RTL and testbench
=============================

# cfg_loader

Configuration word loader sitting directly downstream of the JTAG `tap`. It consumes the 32-bit `config_data` words that `tap` emits with a `config_strobe` pulse while the PROGRAM instruction is active, and frames them as sync, header, payload and checksum. Payload words are written into the configuration memory, and the block reports completion or error. It runs entirely in the `tck` domain.

## Interface
- `ADDR_WIDTH`, 8: configuration memory address width. Memory depth is 2**ADDR_WIDTH words.
- `SYNC_WORD`, 32'hA5C3_0F01: frame start marker.
- `tck` in 1: clock (JTAG TCK). All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `active` in 1: `tap` PROGRAM session active (level).
- `config_data` in 32: word from `tap`. Valid only while `config_strobe`=1.
- `config_strobe` in 1: one-cycle word-valid pulse. May be asserted on consecutive cycles.
- `cfg_addr` out ADDR_WIDTH: memory write address.
- `cfg_wdata` out 32: memory write data.
- `cfg_we` out 1: memory write enable, one-cycle pulse.
- `busy` out 1: load in progress.
- `cfg_done` out 1: sticky; frame loaded and checksum matched.
- `cfg_error` out 1: sticky; frame rejected or aborted.

## Operation
- States: IDLE, SYNC, HEADER, DATA, CHECK, DONE, ERROR.
- Counters and registers:
  - address counter (ADDR_WIDTH bits)
  - remaining counter (17 bits)
  - checksum register (32 bits, XOR accumulator)
- IDLE: when `active`=1, go to SYNC and clear `cfg_done` and `cfg_error`.
- SYNC:
  - A strobe with a word equal to SYNC_WORD goes to HEADER.
  - Any other word is discarded and the state stays SYNC (leading padding is allowed).
  - `active`=0 goes to IDLE with no error.
- HEADER, on strobe: N = word[15:0], start = word[31:16]. The frame is rejected (go to ERROR) if any of the following holds:
  - N = 0
  - start[15:ADDR_WIDTH] is not 0
  - start + N > 2**ADDR_WIDTH (17-bit compare)
- HEADER accept: address counter = start, remaining = N, checksum = header word, go to DATA.
- DATA, on each strobe:
  - Register `cfg_addr` = address counter and `cfg_wdata` = word, and pulse `cfg_we`.
  - checksum ^= word; address counter +1; remaining -1.
  - When remaining goes 1 → 0, go to CHECK.
  - The address counter never wraps, because the header check above guarantees it.
- CHECK, on strobe: word equal to checksum goes to DONE; otherwise go to ERROR. Payload words already written are not rolled back.
- DONE / ERROR:
  - Strobes are ignored.
  - `active`=0 goes to IDLE; `cfg_done` / `cfg_error` are held.
- Abort: `active`=0 while in HEADER, DATA or CHECK goes to ERROR. `active`=0 has priority over a strobe in the same cycle, and that word is dropped with no write.
- `busy` = 1 in SYNC, HEADER, DATA and CHECK.
- `cfg_done` and `cfg_error` are never 1 together.

## Timing
- Reset (async assert, sync release): state IDLE. All outputs are 0: `cfg_addr`, `cfg_wdata`, `cfg_we`, `busy`, `cfg_done`, `cfg_error`. Counters and checksum are 0.
- Reset mid-load aborts immediately. No further `cfg_we` is issued, and no error is flagged.
- All outputs are registered.
- `cfg_we` asserts on the edge after the strobe edge (1-cycle latency) and lasts exactly 1 cycle. `cfg_addr` and `cfg_wdata` are valid in that cycle.
- Back-to-back strobes produce back-to-back `cfg_we` pulses with incrementing addresses. Throughput is one word per cycle.
- State transitions take effect on the strobe edge.
- `cfg_done` / `cfg_error` rise 1 cycle after the checksum-word strobe, or after the failing header/abort edge.
- `busy` falls in that same cycle.
- IDLE→SYNC takes 1 cycle after `active` is sampled high. A strobe in that same cycle is ignored.

## Test plan
- Nominal load: send SYNC_WORD, header 32'h0002_0003, then 32'h1111_1111, 32'h2222_2222, 32'h4444_4444, then checksum 32'h7775_7774.
  - Required: 3 `cfg_we` pulses at addresses 2, 3, 4 with those data values.
  - Required: `cfg_done`=1, `cfg_error`=0, `busy`=0.
  - Repeat with strobes on consecutive cycles; the result must be identical.
- Padding: send 32'hFFFF_FFFF and 32'h0000_0000 before the nominal frame. Required: same result, with no writes for the padding words.
- Bad checksum: nominal frame with last word 32'h7775_7775. Required: 3 writes still occur, then `cfg_error`=1 and `cfg_done`=0.
- Header rejection (ADDR_WIDTH=8), each case separately:
  - header 32'h0000_0000 → `cfg_error`=1, zero writes.
  - header 32'h00FF_0002 → `cfg_error`=1, zero writes.
  - header 32'h00FF_0001 → accepted.
- Abort and recovery:
  - Drop `active` one cycle after the first payload strobe. Required: exactly 1 write, then ERROR, `busy`=0.
  - Reassert `active`. Required: `cfg_error` clears, and a nominal frame then completes with `cfg_done`=1.
- Async reset: assert `rst` between the 2nd and 3rd payload strobes, asynchronously to `tck`.
  - Required: all outputs 0 immediately and the state returns to IDLE.
  - Required: the 3rd strobe issued during reset produces no write.

Source files
------------

// File: rtl/cfg_loader.sv
// ============================================================================
// Module   : cfg_loader
// Purpose  : Frames TAP config words (sync/header/payload/checksum) into
//            configuration-memory writes and reports done/error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] SYNC_WORD  = 32'hA5C3_0F01
) (
    input  logic                  tck,
    input  logic                  rst,
    input  logic                  active,
    input  logic [31:0]           config_data,
    input  logic                  config_strobe,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [31:0]           cfg_wdata,
    output logic                  cfg_we,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_error
);

    localparam logic [16:0] MEM_DEPTH = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_HEADER = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [16:0]           remaining_q, remaining_d;
    logic [31:0]           csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_d;
    logic [31:0]           cfg_wdata_q, cfg_wdata_d;
    logic                  cfg_we_q, cfg_we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic [15:0] hdr_n;
    logic [15:0] hdr_start;
    logic [16:0] hdr_end;
    logic        hdr_bad;

    assign hdr_n     = config_data[15:0];
    assign hdr_start = config_data[31:16];
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_n};
    // Bounding start+N here is what lets the address counter run without wrap checks.
    assign hdr_bad   = (hdr_n == 16'd0) ||
                       ((hdr_start >> ADDR_WIDTH) != 16'd0) ||
                       (hdr_end > MEM_DEPTH);

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        remaining_d = remaining_q;
        csum_d      = csum_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_we_d    = 1'b0;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE: begin
                if (active) begin
                    state_d = S_SYNC;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            S_SYNC: begin
                if (!active) begin
                    state_d = S_IDLE;
                end else if (config_strobe && (config_data == SYNC_WORD)) begin
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (!active) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else if (config_strobe) begin
                    if (hdr_bad) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d     = S_DATA;
                        addr_cnt_d  = hdr_start[ADDR_WIDTH-1:0];
                        remaining_d = {1'b0, hdr_n};
                        csum_d      = config_data;
                    end
                end
            end
            S_DATA: begin
                if (!active) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else if (config_strobe) begin
                    cfg_we_d    = 1'b1;
                    cfg_addr_d  = addr_cnt_q;
                    cfg_wdata_d = config_data;
                    csum_d      = csum_q ^ config_data;
                    addr_cnt_d  = addr_cnt_q + 1'b1;
                    remaining_d = remaining_q - 17'd1;
                    if (remaining_q == 17'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (!active) begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end else if (config_strobe) begin
                    if (config_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (!active) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SYNC) || (state_d == S_HEADER) ||
                 (state_d == S_DATA) || (state_d == S_CHECK);
    end

    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            csum_q      <= '0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            cfg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            remaining_q <= remaining_d;
            csum_q      <= csum_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_we_q    <= cfg_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign cfg_addr  = cfg_addr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign cfg_we    = cfg_we_q;
    assign busy      = busy_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_cfg_loader.sv
// ============================================================================
// Module   : tb_cfg_loader
// Purpose  : Directed and randomized frames for cfg_loader, checked against a
//            stream-parsing reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfg_loader;

    localparam logic [31:0] SYNC = 32'hA5C3_0F01;

    logic        tck;
    logic        rst;
    logic        active;
    logic [31:0] config_data;
    logic        config_strobe;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_we;
    logic        busy;
    logic        cfg_done;
    logic        cfg_error;

    cfg_loader #(
        .ADDR_WIDTH (8),
        .SYNC_WORD  (SYNC)
    ) dut (
        .tck           (tck),
        .rst           (rst),
        .active        (active),
        .config_data   (config_data),
        .config_strobe (config_strobe),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_we        (cfg_we),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .cfg_error     (cfg_error)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int vectors = 0;
    int fails   = 0;

    logic [31:0] frame[$];
    logic [31:0] obs_a[$];
    logic [31:0] obs_d[$];
    int          exp_a[$];
    logic [31:0] exp_d[$];
    logic        exp_done;
    logic        exp_err;

    always @(negedge tck) begin
        if (cfg_we === 1'b1) begin
            obs_a.push_back({24'd0, cfg_addr});
            obs_d.push_back(cfg_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        vectors++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Reference: scan for sync, validate header, payload -> writes, XOR checksum.
    task automatic model();
        int i;
        int n;
        int st;
        logic [31:0] hdr;
        logic [31:0] cs;
        exp_a.delete();
        exp_d.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < frame.size() && frame[i] != SYNC) i++;
        if (i + 1 >= frame.size()) return;
        hdr = frame[i+1];
        n   = int'(hdr[15:0]);
        st  = int'(hdr[31:16]);
        if (n == 0 || st >= 256 || st + n > 256) begin
            exp_err = 1'b1;
            return;
        end
        cs = hdr;
        for (int k = 0; k < n; k++) begin
            if (i + 2 + k >= frame.size()) return;
            exp_a.push_back(st + k);
            exp_d.push_back(frame[i+2+k]);
            cs = cs ^ frame[i+2+k];
        end
        if (i + 2 + n < frame.size()) begin
            exp_done = (frame[i+2+n] == cs);
            exp_err  = !exp_done;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        config_data   = w;
        config_strobe = 1'b1;
        @(negedge tck);
        config_strobe = 1'b0;
        config_data   = $urandom;
    endtask

    task automatic check_writes(input string tag, input int base);
        int nobs;
        nobs = obs_a.size() - base;
        chk({tag, ".nwr"}, 32'(nobs), 32'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && k < nobs; k++) begin
            chk({tag, ".addr"}, obs_a[base+k], 32'(exp_a[k]));
            chk({tag, ".data"}, obs_d[base+k], exp_d[k]);
        end
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle, 2 random 0..2 idle cycles
    task automatic run_frame(input string tag, input int gap_mode);
        int base;
        base = obs_a.size();
        model();
        active = 1'b1;
        @(negedge tck);
        chk({tag, ".start_busy"}, 32'(busy), 32'd1);
        chk({tag, ".start_done"}, 32'(cfg_done), 32'd0);
        chk({tag, ".start_err"}, 32'(cfg_error), 32'd0);
        foreach (frame[j]) begin
            send_word(frame[j]);
            if (gap_mode == 1) @(negedge tck);
            else if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge tck);
        end
        repeat (3) @(negedge tck);
        check_writes(tag, base);
        chk({tag, ".done"}, 32'(cfg_done), 32'(exp_done));
        chk({tag, ".err"}, 32'(cfg_error), 32'(exp_err));
        chk({tag, ".busy"}, 32'(busy), 32'(!(exp_done || exp_err)));
        active = 1'b0;
        repeat (2) @(negedge tck);
        chk({tag, ".held_done"}, 32'(cfg_done), 32'(exp_done));
        chk({tag, ".held_err"}, 32'(cfg_error), 32'(exp_err));
    endtask

    task automatic nominal(input logic [31:0] last);
        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(32'h0002_0003);
        frame.push_back(32'h1111_1111);
        frame.push_back(32'h2222_2222);
        frame.push_back(32'h4444_4444);
        frame.push_back(last);
    endtask

    initial begin
        int base;
        int n;
        logic [15:0] st;
        logic [31:0] w;
        logic [31:0] cs;

        rst           = 1'b1;
        active        = 1'b0;
        config_data   = '0;
        config_strobe = 1'b0;
        repeat (3) @(negedge tck);
        chk("rst.addr", {24'd0, cfg_addr}, 32'd0);
        chk("rst.wdata", cfg_wdata, 32'd0);
        chk("rst.we", 32'(cfg_we), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(cfg_done), 32'd0);
        chk("rst.err", 32'(cfg_error), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge tck);

        nominal(32'h7775_7774);
        run_frame("nom_gap", 1);
        chk("nom_gap.model_done", 32'(exp_done), 32'd1);
        run_frame("nom_b2b", 0);

        nominal(32'h7775_7774);
        frame.push_front(32'h0000_0000);
        frame.push_front(32'hFFFF_FFFF);
        run_frame("padding", 2);

        nominal(32'h7775_7775);
        run_frame("bad_csum", 0);

        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(32'h0000_0000);
        run_frame("hdr_n0", 0);

        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(32'h00FF_0002);
        frame.push_back(32'h1234_5678);
        frame.push_back(32'h9ABC_DEF0);
        run_frame("hdr_ovf", 0);

        frame.delete();
        frame.push_back(SYNC);
        frame.push_back(32'h00FF_0001);
        frame.push_back(32'hCAFE_F00D);
        frame.push_back(32'h00FF_0001 ^ 32'hCAFE_F00D);
        run_frame("hdr_edge", 0);

        // Abort one cycle after the first payload strobe.
        base   = obs_a.size();
        active = 1'b1;
        @(negedge tck);
        send_word(SYNC);
        send_word(32'h0002_0003);
        send_word(32'h1111_1111);
        active = 1'b0;
        repeat (2) @(negedge tck);
        chk("abort.nwr", 32'(obs_a.size() - base), 32'd1);
        if (obs_a.size() > base) begin
            chk("abort.addr", obs_a[base], 32'd2);
            chk("abort.data", obs_d[base], 32'h1111_1111);
        end
        chk("abort.err", 32'(cfg_error), 32'd1);
        chk("abort.done", 32'(cfg_done), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        nominal(32'h7775_7774);
        run_frame("recover", 0);

        // Async reset between 2nd and 3rd payload strobes.
        base   = obs_a.size();
        active = 1'b1;
        @(negedge tck);
        send_word(SYNC);
        send_word(32'h0002_0003);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        #2 rst = 1'b1;
        #1;
        chk("arst.addr", {24'd0, cfg_addr}, 32'd0);
        chk("arst.wdata", cfg_wdata, 32'd0);
        chk("arst.we", 32'(cfg_we), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        chk("arst.done", 32'(cfg_done), 32'd0);
        chk("arst.err", 32'(cfg_error), 32'd0);
        @(negedge tck);
        send_word(32'h4444_4444);
        active = 1'b0;
        @(negedge tck);
        rst = 1'b0;
        repeat (3) @(negedge tck);
        chk("arst.nwr", 32'(obs_a.size() - base), 32'd2);
        chk("arst.idle_busy", 32'(busy), 32'd0);
        chk("arst.idle_err", 32'(cfg_error), 32'd0);
        chk("arst.idle_done", 32'(cfg_done), 32'd0);

        for (int r = 0; r < 24; r++) begin
            frame.delete();
            repeat ($urandom_range(0, 2)) begin
                w = $urandom;
                if (w == SYNC) w = 32'd0;
                frame.push_back(w);
            end
            frame.push_back(SYNC);
            n  = $urandom_range(0, 6);
            st = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) st = st | 16'h0100;
            w  = {st, 16'(n)};
            frame.push_back(w);
            cs = w;
            for (int k = 0; k < n; k++) begin
                w  = $urandom;
                cs = cs ^ w;
                frame.push_back(w);
            end
            if ($urandom_range(0, 3) == 0) cs = cs ^ (32'd1 << $urandom_range(0, 31));
            frame.push_back(cs);
            run_frame("rand", 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
